// File: rtl/uart_cmd_ctl.sv
// UART receive-path command sequencer: collects SOF/ADDR/DATA/CHK frames,
// validates them and commits DATA into a small configuration register bank.
module uart_cmd_ctl #(
  parameter int          NREG        = 4,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC = 163840,
  parameter int          TW          = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              rx_en,
  output logic [8*NREG-1:0] cfg_regs,
  output logic              wr_stb,
  output logic [7:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              frm_err,
  output logic [1:0]        err_code,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] d);
    return a + d;
  endfunction

  state_t            state_r, next_state_s;
  logic [TW-1:0]     to_cnt_r;
  logic [7:0]        addr_r, data_r;
  logic              to_hit_s, commit_s, reject_s;
  logic [1:0]        err_code_s;
  logic              rx_en_r, wr_stb_r, frm_err_r;
  logic [7:0]        wr_addr_r, wr_data_r, err_cnt_r;
  logic [1:0]        err_code_r;
  logic [8*NREG-1:0] cfg_regs_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state decode; a byte always beats a coincident timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (rx_done && (rx_data == SOF_BYTE)) next_state_s = GET_ADDR;
        else                                  next_state_s = IDLE;
      end
      GET_ADDR: begin
        if (rx_done)       next_state_s = GET_DATA;
        else if (to_hit_s) next_state_s = IDLE;
        else               next_state_s = GET_ADDR;
      end
      GET_DATA: begin
        if (rx_done)       next_state_s = GET_CHK;
        else if (to_hit_s) next_state_s = IDLE;
        else               next_state_s = GET_DATA;
      end
      GET_CHK: begin
        if (rx_done || to_hit_s) next_state_s = IDLE;
        else                     next_state_s = GET_CHK;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Frame verdict: commit, checksum/address reject, or inter-byte timeout
  always_comb begin
    commit_s   = 1'b0;
    reject_s   = 1'b0;
    err_code_s = err_code_r;
    to_hit_s   = (state_r != IDLE) && !rx_done && (to_cnt_r == TW'(TIMEOUT_CYC - 1));
    if ((state_r == GET_CHK) && rx_done) begin
      if (rx_data != frame_chk(addr_r, data_r)) begin
        reject_s   = 1'b1;
        err_code_s = 2'b01;
      end else if (addr_r >= 8'(NREG)) begin
        reject_s   = 1'b1;
        err_code_s = 2'b10;
      end else begin
        commit_s   = 1'b1;
      end
    end else if (to_hit_s) begin
      reject_s   = 1'b1;
      err_code_s = 2'b11;
    end else begin
      commit_s   = 1'b0;
    end
  end

  // Inter-byte timeout counter and frame field capture
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= {TW{1'b0}};
      addr_r   <= 8'h00;
      data_r   <= 8'h00;
    end else begin
      if (rx_done || (state_r == IDLE) || to_hit_s) to_cnt_r <= {TW{1'b0}};
      else                                          to_cnt_r <= to_cnt_r + TW'(1);
      if (rx_done && (state_r == GET_ADDR)) addr_r <= rx_data;
      if (rx_done && (state_r == GET_DATA)) data_r <= rx_data;
    end
  end

  // Registered outputs and configuration bank
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_en_r    <= 1'b0;
      wr_stb_r   <= 1'b0;
      frm_err_r  <= 1'b0;
      wr_addr_r  <= 8'h00;
      wr_data_r  <= 8'h00;
      err_code_r <= 2'b00;
      err_cnt_r  <= 8'h00;
      cfg_regs_r <= {(8*NREG){1'b0}};
    end else begin
      rx_en_r    <= !rx_done;
      wr_stb_r   <= commit_s;
      frm_err_r  <= reject_s;
      err_code_r <= err_code_s;
      if (commit_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= data_r;
      end
      if (reject_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'h01;
      for (int i = 0; i < NREG; i++) begin
        if (commit_s && (addr_r == 8'(i))) cfg_regs_r[8*i +: 8] <= data_r;
      end
    end
  end

  assign rx_en    = rx_en_r;
  assign wr_stb   = wr_stb_r;
  assign frm_err  = frm_err_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign err_code = err_code_r;
  assign err_cnt  = err_cnt_r;
  assign cfg_regs = cfg_regs_r;

endmodule

// File: tb/tb_uart_cmd_ctl.sv
// Directed bench for uart_cmd_ctl; frame outcomes are predicted by a small
// model, queued at stimulus time and compared when wr_stb/frm_err fire.
module tb_uart_cmd_ctl;
  localparam int T = 200;

  logic        clk = 1'b0, reset = 1'b1, rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_en, wr_stb, frm_err;
  logic [31:0] cfg_regs;
  logic [7:0]  wr_addr, wr_data, err_cnt;
  logic [1:0]  err_code;

  uart_cmd_ctl #(.NREG(4), .SOF_BYTE(8'hA5), .TIMEOUT_CYC(T), .TW(8)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .rx_en(rx_en), .cfg_regs(cfg_regs), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .frm_err(frm_err), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  addr, data, cnt;
    logic [1:0]  code;
    logic [31:0] regs;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_ev;
  logic [31:0] m_regs = 32'h0;
  logic [7:0]  m_cnt = 8'h00, m_waddr = 8'h00, m_wdata = 8'h00;
  logic [1:0]  m_code = 2'b00;
  int          n_pass = 0, n_fail = 0, n_chk = 0;
  int          last_edge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every write/error pulse against the oldest predicted event
  always @(negedge clk) begin
    if (wr_stb || frm_err) begin
      chk("pulse_exclusive", {31'b0, wr_stb & frm_err}, 32'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'b0, wr_stb, frm_err}, 32'h0);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("event_cycle", cyc, mon_ev.cyc);
        chk("event_is_err", {31'b0, frm_err}, {31'b0, mon_ev.is_err});
        if (mon_ev.is_err) chk("err_code", {30'b0, err_code}, {30'b0, mon_ev.code});
        else begin
          chk("wr_addr", {24'b0, wr_addr}, {24'b0, mon_ev.addr});
          chk("wr_data", {24'b0, wr_data}, {24'b0, mon_ev.data});
        end
        chk("err_cnt", {24'b0, err_cnt}, {24'b0, mon_ev.cnt});
        chk("cfg_regs", cfg_regs, mon_ev.regs);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int ec;
    rx_data = b;
    rx_done = 1'b1;
    ec = cyc + 1;
    @(posedge clk); #1;
    rx_done   = 1'b0;
    last_edge = ec;
    chk("rx_en_after_done", {31'b0, rx_en}, 32'h0);
    @(posedge clk); #1;
    chk("rx_en_recovered", {31'b0, rx_en}, 32'h1);
  endtask

  task automatic push_err(input logic [1:0] code, input int at);
    ev_t e;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
    m_code = code;
    e.is_err = 1'b1; e.code = code; e.cnt = m_cnt; e.regs = m_regs;
    e.addr = m_waddr; e.data = m_wdata; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    logic [7:0] sum;
    ev_t e;
    send(8'hA5); send(a); send(d);
    sum = a + d;
    if (c != sum) push_err(2'b01, cyc + 1);
    else if (a >= 8'd4) push_err(2'b10, cyc + 1);
    else begin
      m_regs[a*8 +: 8] = d;
      m_waddr = a; m_wdata = d;
      e.is_err = 1'b0; e.code = m_code; e.cnt = m_cnt; e.regs = m_regs;
      e.addr = a; e.data = d; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    send(c);
  endtask

  task automatic drain();
    for (int i = 0; i < T + 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("queue_drained", exp_q.size(), 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rx_en"},    {31'b0, rx_en}, 32'h0);
    chk({tag, "_cfg"},      cfg_regs, 32'h0);
    chk({tag, "_wr_stb"},   {31'b0, wr_stb}, 32'h0);
    chk({tag, "_frm_err"},  {31'b0, frm_err}, 32'h0);
    chk({tag, "_wr_addr"},  {24'b0, wr_addr}, 32'h0);
    chk({tag, "_wr_data"},  {24'b0, wr_data}, 32'h0);
    chk({tag, "_err_code"}, {30'b0, err_code}, 32'h0);
    chk({tag, "_err_cnt"},  {24'b0, err_cnt}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    chk("rx_en_first_cycle", {31'b0, rx_en}, 32'h0);
    @(posedge clk); #1;
    chk("rx_en_second_cycle", {31'b0, rx_en}, 32'h1);

    frame(8'h01, 8'h3C, 8'h3D); drain();
    chk("cfg_after_a", cfg_regs, 32'h0000_3C00);

    frame(8'h02, 8'hFF, 8'h02); drain();
    chk("err_code_chk", {30'b0, err_code}, 32'h1);
    frame(8'h02, 8'hFF, 8'h01); drain();
    chk("cfg_after_wrap", cfg_regs, 32'h00FF_3C00);

    frame(8'h07, 8'h11, 8'h18); drain();
    chk("wr_addr_held", {24'b0, wr_addr}, 32'h02);
    chk("wr_data_held", {24'b0, wr_data}, 32'hFF);

    send(8'h33); send(8'hA5); send(8'h00); send(8'h55);
    push_err(2'b11, last_edge + T);
    drain();
    chk("err_code_timeout", {30'b0, err_code}, 32'h3);
    frame(8'h00, 8'h55, 8'h55); drain();
    chk("cfg_after_timeout", cfg_regs, 32'h00FF_3C55);
    chk("err_code_held", {30'b0, err_code}, 32'h3);

    for (int i = 0; i < 256; i++) frame(8'h00, 8'h00, 8'h01);
    drain();
    chk("err_cnt_saturated", {24'b0, err_cnt}, 32'hFF);

    send(8'hA5); send(8'h03);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midframe_reset");
    m_regs = 32'h0; m_cnt = 8'h00; m_code = 2'b00; m_waddr = 8'h00; m_wdata = 8'h00;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_err_cnt", {24'b0, err_cnt}, 32'h0);
    frame(8'h03, 8'h10, 8'h13); drain();
    chk("cfg_after_reset_frame", cfg_regs, 32'h1000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctl.md
Name: uart_cmd_ctl

Overview:
- Command sequencer for the UART receive path.
- Drives the receiver's byte-enable handshake and collects received bytes into 4-byte frames: SOF, ADDR, DATA, CHK.
- Validates each frame and writes DATA into a small configuration register bank that downstream blocks (LED drivers, future BDC control) read.
- Sits between rx_module and all UART-configurable logic; it replaces per-byte ad-hoc decoding.

Parameters:
- NREG, 4, number of 8-bit config registers; valid addresses are 0..NREG-1.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYC, 163840, inter-byte timeout in clk cycles (~3.3 ms at 49.152 MHz).
- TW, 18, timeout counter width; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- clk  input  1  system clock, 49.152 MHz.
- reset  input  1  synchronous, active-high reset.
- rx_done  input  1  single-cycle pulse from the receiver: a byte is valid on rx_data.
- rx_data  input  8  received byte, sampled only when rx_done=1.
- rx_en  output  1  receive enable to the receiver.
- cfg_regs  output  8*NREG  register bank; reg i occupies bits [8i+7:8i].
- wr_stb  output  1  one-cycle pulse on each committed write.
- wr_addr  output  8  address of the last committed write.
- wr_data  output  8  data of the last committed write.
- frm_err  output  1  one-cycle pulse on frame rejection.
- err_code  output  2  cause of the last rejection: 01 checksum, 10 bad address, 11 timeout; 00 after reset.
- err_cnt  output  8  rejected-frame count, saturating at 255.

Behaviour:
- All outputs are registered. Only the synchronous reset initialises state: it is sampled on the clk rising edge.

Reset (synchronous, sampled on clk rising edge):
- State goes to IDLE.
- rx_en=0, cfg_regs=0, wr_stb=0, wr_addr=0, wr_data=0, frm_err=0, err_code=0, err_cnt=0, timeout counter=0.
- Reset in the middle of a frame discards the partial frame; no write and no error are reported.

rx_en handshake:
- Next value is !rx_done: rx_en drops for exactly the one cycle after each rx_done, then returns to 1.
- First cycle after reset release: rx_en=0; it is 1 from the following cycle on.

FSM states: IDLE, GET_ADDR, GET_DATA, GET_CHK.
- IDLE: on rx_done with rx_data==SOF_BYTE, go to GET_ADDR. Any other byte is ignored; stay in IDLE.
- GET_ADDR: on rx_done, latch addr, go to GET_DATA. SOF_BYTE gets no special treatment here; it is taken as an address.
- GET_DATA: on rx_done, latch data, go to GET_CHK.
- GET_CHK: on rx_done, go to IDLE and evaluate the frame:
  - Checksum: chk_exp = (addr + data) mod 256, 8-bit wrap-around.
  - If rx_data != chk_exp: reject with err_code=01.
  - Else if addr >= NREG: reject with err_code=10.
  - Else: commit the write.

Commit (CHK rx_done at cycle N):
- In cycle N+1: wr_stb=1, wr_addr=addr, wr_data=data, and cfg_regs[addr] holds the new data.
- Other registers are unchanged.

Reject (CHK rx_done at cycle N):
- In cycle N+1: frm_err=1, err_code updated, err_cnt incremented (saturating at 255).
- No register write occurs.

Timeout:
- The counter clears on every rx_done and while in IDLE, and increments in every other cycle spent in GET_*.
- When the counter equals TIMEOUT_CYC-1 with no rx_done in that cycle: go to IDLE, pulse frm_err next cycle, set err_code=11, increment err_cnt.
- If rx_done and the timeout terminal count land in the same cycle, rx_done wins and no timeout is raised.

Other rules:
- wr_stb and frm_err are mutually exclusive and each is high for exactly one cycle per event.
- err_code holds its value until the next rejection.
- wr_addr and wr_data hold until the next commit.
- Back-to-back frames are allowed. A SOF arriving in the cycle after a commit is accepted normally.

Test Plan:
- Frame A5,01,3C,3D → wr_stb one cycle after the CHK rx_done, with wr_addr=01, wr_data=3C; cfg_regs[15:8]=3C; all other registers stay 0; err_cnt=0.
- Frame A5,02,FF,02 (checksum wraps: 02+FF=101h → 01) → frm_err pulse, err_code=01, err_cnt=1, cfg_regs unchanged. Follow with A5,02,FF,01 → commit; cfg_regs[23:16]=FF.
- Frame A5,07,11,18 with NREG=4 → frm_err, err_code=10, no wr_stb.
- Bytes 33,A5,00,55, then silence → the leading 33 is ignored; TIMEOUT_CYC cycles after the last rx_done, frm_err fires with err_code=11 and the FSM is in IDLE. A following frame A5,00,55,55 then commits cfg_regs[7:0]=55.
- rx_en check: rx_en=0 in the first cycle after reset release, then 1. For each rx_done pulse, rx_en=0 in exactly the next cycle.
- Saturation and reset: 256 consecutive bad-checksum frames leave err_cnt=FF. Reset asserted after A5,03 (mid-frame) clears err_cnt to 0 and cfg_regs to 0, with no wr_stb and no frm_err.
